// File: rtl/l2_sio_mon_pkg.sv
// Shared definitions for the L2-to-SIO response tracker: header field positions,
// the read-opcode mask, the per-bank FSM state encoding and the completion record.
// Ports: none (package).
package l2_sio_mon_pkg;

  // Header field positions within the 32-bit header beat.
  localparam int OPES_LSB = 20;
  localparam int CBA_LSB  = 16;
  localparam int TAG_LSB  = 0;

  // A header is a read (carries payload) when the masked opes bits are all zero.
  localparam logic [3:0] RD_OPES_MASK = 4'b1100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } bank_state_e;

  // One completed transaction as held in a pending slot and the output register.
  typedef struct packed {
    logic [3:0]  opes;
    logic [3:0]  cba;
    logic [15:0] tag;
    logic        par_err;
    logic        ue;
    logic        proto_err;
  } evt_rec_t;

  // Decode the header fields; error flags start clear.
  function automatic evt_rec_t decode_hdr(input logic [23:0] hdr);
    evt_rec_t r;
    r.opes      = hdr[OPES_LSB+:4];
    r.cba       = hdr[CBA_LSB+:4];
    r.tag       = hdr[TAG_LSB+:16];
    r.par_err   = 1'b0;
    r.ue        = 1'b0;
    r.proto_err = 1'b0;
    return r;
  endfunction

  function automatic logic is_read(input logic [3:0] opes);
    return (opes & RD_OPES_MASK) == 4'b0000;
  endfunction

endpackage

// File: rtl/l2_sio_bank_fsm.sv
// One bank's response tracker: header capture, payload beat counting, parity and UE flags.
// Latency: done pulses combinationally in the header cycle (ack-only) or the final payload beat.
// Backpressure: none; the bank bus cannot stall, the top decides whether the completion is kept.
// Ports: iol2clk/rst_l; ctag_vld/data/parity/ue_err from the bank; busy = not IDLE;
//        done + done_rec present the completing transaction for the pending slot.
module l2_sio_bank_fsm
  import l2_sio_mon_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int RD_BEATS = 16
) (
  input  logic              iol2clk,
  input  logic              rst_l,
  input  logic              ctag_vld,
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        parity,
  input  logic              ue_err,
  output logic              busy,
  output logic              done,
  output evt_rec_t          done_rec
);

  localparam int CW = (RD_BEATS > 1) ? $clog2(RD_BEATS) : 1;

  bank_state_e    state, state_nxt;
  logic [CW-1:0]  beat_cnt, beat_cnt_nxt;
  evt_rec_t       rec, rec_nxt;
  evt_rec_t       hdr_rec;
  logic           par_bad;

  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      rec      <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      rec      <= rec_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    rec_nxt      = rec;
    done         = 1'b0;
    done_rec     = rec;

    // A header seen this cycle, with this cycle's UE already attached to it.
    hdr_rec      = decode_hdr(data[23:0]);
    hdr_rec.ue   = ue_err;
    par_bad      = (parity != {^data[31:16], ^data[15:0]});

    case (state)
      ST_IDLE: begin
        if (ctag_vld) begin
          rec_nxt = hdr_rec;
          if (is_read(hdr_rec.opes)) begin
            state_nxt    = ST_DATA;
            beat_cnt_nxt = '0;
          end else begin
            done     = 1'b1;
            done_rec = hdr_rec;
          end
        end
      end
      ST_DATA: begin
        if (ctag_vld) begin
          // Header arrived mid-payload: report the aborted read and restart on the new one.
          // An ack-only header arriving here cannot also complete this cycle, so only the
          // aborted read is reported and the bank returns to IDLE.
          done               = 1'b1;
          done_rec           = rec;
          done_rec.proto_err = 1'b1;
          rec_nxt            = hdr_rec;
          beat_cnt_nxt       = '0;
          if (!is_read(hdr_rec.opes)) begin
            state_nxt = ST_IDLE;
          end
        end else begin
          rec_nxt.par_err = rec.par_err | par_bad;
          rec_nxt.ue      = rec.ue | ue_err;
          if (beat_cnt == CW'(RD_BEATS - 1)) begin
            done      = 1'b1;
            done_rec  = rec_nxt;
            state_nxt = ST_IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_DATA);

endmodule

// File: rtl/l2_sio_resp_tracker.sv
// Tracks L2 bank responses toward SIO and emits one completion event per transaction.
// Latency: evt_vld rises 2 edges after the header (ack-only) or the final payload beat.
// Backpressure: evt_vld/evt_rdy; one pending slot per bank, a completion into a full slot is dropped and sets ovf_sticky.
// Ports: iol2clk/rst_l; l2b_sio_* per-bank inputs (bank b at data[b*32+:32], parity[b*2+:2]);
//        evt_* event handshake and fields; bank_busy, ovf_sticky, ue_cnt status.
module l2_sio_resp_tracker
  import l2_sio_mon_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int DATA_W    = 32,
  parameter int RD_BEATS  = 16,
  parameter int CNT_W     = 16
) (
  input  logic                        iol2clk,
  input  logic                        rst_l,
  input  logic [NUM_BANKS-1:0]        l2b_sio_ctag_vld,
  input  logic [NUM_BANKS*DATA_W-1:0] l2b_sio_data,
  input  logic [NUM_BANKS*2-1:0]      l2b_sio_parity,
  input  logic [NUM_BANKS-1:0]        l2b_sio_ue_err,
  output logic                        evt_vld,
  input  logic                        evt_rdy,
  output logic [2:0]                  evt_bank,
  output logic [3:0]                  evt_opes,
  output logic [3:0]                  evt_cba,
  output logic [15:0]                 evt_tag,
  output logic                        evt_par_err,
  output logic                        evt_ue,
  output logic                        evt_proto_err,
  output logic [NUM_BANKS-1:0]        bank_busy,
  output logic                        ovf_sticky,
  output logic [CNT_W-1:0]            ue_cnt
);

  localparam int BW = 3;

  logic [NUM_BANKS-1:0] done;
  evt_rec_t             done_rec [NUM_BANKS];
  logic                 pend_vld [NUM_BANKS];
  evt_rec_t             pend_rec [NUM_BANKS];
  logic [NUM_BANKS-1:0] slot_clr;
  logic [NUM_BANKS-1:0] ovf_hit;

  logic [BW-1:0]        rr_ptr;
  logic [BW:0]          rr_idx;
  logic [BW-1:0]        gnt_idx;
  logic                 gnt_any;
  logic                 load_en;
  logic                 grant;
  evt_rec_t             out_rec;

  logic [3:0]           ue_sum;
  logic [CNT_W:0]       ue_add;
  logic [CNT_W-1:0]     ue_cnt_nxt;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    l2_sio_bank_fsm #(
      .DATA_W  (DATA_W),
      .RD_BEATS(RD_BEATS)
    ) u_fsm (
      .iol2clk (iol2clk),
      .rst_l   (rst_l),
      .ctag_vld(l2b_sio_ctag_vld[b]),
      .data    (l2b_sio_data[b*DATA_W+:DATA_W]),
      .parity  (l2b_sio_parity[b*2+:2]),
      .ue_err  (l2b_sio_ue_err[b]),
      .busy    (bank_busy[b]),
      .done    (done[b]),
      .done_rec(done_rec[b])
    );

    assign slot_clr[b] = grant && (gnt_idx == BW'(b));
    // The granted slot empties on this edge, so a completion landing now refills it cleanly.
    assign ovf_hit[b]  = done[b] && pend_vld[b] && !slot_clr[b];

    always_ff @(posedge iol2clk or negedge rst_l) begin
      if (!rst_l) begin
        pend_vld[b] <= 1'b0;
        pend_rec[b] <= '0;
      end else if (done[b] && (!pend_vld[b] || slot_clr[b])) begin
        pend_vld[b] <= 1'b1;
        pend_rec[b] <= done_rec[b];
      end else if (slot_clr[b]) begin
        pend_vld[b] <= 1'b0;
      end
    end
  end

  // Round-robin search over full slots starting at rr_ptr.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_idx  = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      rr_idx = {1'b0, rr_ptr} + (BW+1)'(i);
      if (rr_idx >= (BW+1)'(NUM_BANKS)) begin
        rr_idx = rr_idx - (BW+1)'(NUM_BANKS);
      end
      if (!gnt_any && pend_vld[rr_idx[BW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_idx[BW-1:0];
      end
    end
  end

  assign load_en = !evt_vld || evt_rdy;
  assign grant   = load_en && gnt_any;

  // Per-cycle UE count across banks, saturating.
  always_comb begin
    ue_sum = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      ue_sum = ue_sum + {3'b000, l2b_sio_ue_err[i]};
    end
    ue_add     = {1'b0, ue_cnt} + {{(CNT_W-3){1'b0}}, ue_sum};
    ue_cnt_nxt = ue_add[CNT_W] ? '1 : ue_add[CNT_W-1:0];
  end

  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      evt_vld    <= 1'b0;
      evt_bank   <= '0;
      out_rec    <= '0;
      rr_ptr     <= '0;
      ovf_sticky <= 1'b0;
      ue_cnt     <= '0;
    end else begin
      if (load_en) begin
        if (gnt_any) begin
          evt_vld  <= 1'b1;
          evt_bank <= gnt_idx;
          out_rec  <= pend_rec[gnt_idx];
          rr_ptr   <= (gnt_idx == BW'(NUM_BANKS - 1)) ? '0 : gnt_idx + 1'b1;
        end else begin
          evt_vld <= 1'b0;
        end
      end
      if (|ovf_hit) begin
        ovf_sticky <= 1'b1;
      end
      ue_cnt <= ue_cnt_nxt;
    end
  end

  assign evt_opes      = out_rec.opes;
  assign evt_cba       = out_rec.cba;
  assign evt_tag       = out_rec.tag;
  assign evt_par_err   = out_rec.par_err;
  assign evt_ue        = out_rec.ue;
  assign evt_proto_err = out_rec.proto_err;

endmodule

// File: tb/tb_l2_sio_resp_tracker.sv
// Self-checking bench for l2_sio_resp_tracker: expected events are queued as stimulus is
// driven and compared in order as the DUT hands them over on evt_vld && evt_rdy.
module tb_l2_sio_resp_tracker;

  typedef struct packed {
    logic [2:0]  bank;
    logic [3:0]  opes;
    logic [3:0]  cba;
    logic [15:0] tag;
    logic        pe;
    logic        ue;
    logic        pro;
  } exp_t;

  logic         iol2clk = 1'b0;
  logic         rst_l;
  logic [7:0]   ctag;
  logic [255:0] data;
  logic [15:0]  par;
  logic [7:0]   ue;
  logic         evt_rdy;
  logic         evt_vld;
  logic [2:0]   evt_bank;
  logic [3:0]   evt_opes;
  logic [3:0]   evt_cba;
  logic [15:0]  evt_tag;
  logic         evt_par_err;
  logic         evt_ue;
  logic         evt_proto_err;
  logic [7:0]   bank_busy;
  logic         ovf_sticky;
  logic [15:0]  ue_cnt;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  exp_t mon_got;
  exp_t mon_exp;
  exp_t prev_got;
  logic prev_vld = 1'b0;
  logic prev_rdy = 1'b0;

  always #5 iol2clk = ~iol2clk;

  l2_sio_resp_tracker dut (
    .iol2clk         (iol2clk),
    .rst_l           (rst_l),
    .l2b_sio_ctag_vld(ctag),
    .l2b_sio_data    (data),
    .l2b_sio_parity  (par),
    .l2b_sio_ue_err  (ue),
    .evt_vld         (evt_vld),
    .evt_rdy         (evt_rdy),
    .evt_bank        (evt_bank),
    .evt_opes        (evt_opes),
    .evt_cba         (evt_cba),
    .evt_tag         (evt_tag),
    .evt_par_err     (evt_par_err),
    .evt_ue          (evt_ue),
    .evt_proto_err   (evt_proto_err),
    .bank_busy       (bank_busy),
    .ovf_sticky      (ovf_sticky),
    .ue_cnt          (ue_cnt)
  );

  // Scoreboard side: pop on every accepted event, and check hold while stalled.
  always @(negedge iol2clk) begin
    mon_got = {evt_bank, evt_opes, evt_cba, evt_tag, evt_par_err, evt_ue, evt_proto_err};
    if (!rst_l) begin
      prev_vld = 1'b0;
    end else begin
      if (prev_vld && !prev_rdy) begin
        checks++;
        if (!evt_vld || mon_got !== prev_got) begin
          errors++;
          $display("FAIL evt_hold got vld=%0b %h exp vld=1 %h", evt_vld, mon_got, prev_got);
        end
      end
      if (evt_vld && evt_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL evt_unexpected got %h exp none", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL evt_fields got %h exp %h", mon_got, mon_exp);
          end
        end
      end
      prev_vld = evt_vld;
      prev_rdy = evt_rdy;
      prev_got = mon_got;
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

  function automatic logic [1:0] gpar(input logic [31:0] d);
    return {^d[31:16], ^d[15:0]};
  endfunction

  task automatic clr_in();
    ctag = '0;
    data = '0;
    par  = '0;
    ue   = '0;
  endtask

  task automatic step();
    @(posedge iol2clk);
    #1;
    clr_in();
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    clr_in();
    exp_q.delete();
    repeat (2) @(posedge iol2clk);
    #1;
    rst_l = 1'b1;
  endtask

  task automatic set_hdr(input int b, input logic [31:0] h);
    ctag[b]        = 1'b1;
    data[b*32+:32] = h;
    par[b*2+:2]    = gpar(h);
  endtask

  task automatic set_beat(input int b, input logic flip, input logic u);
    logic [31:0] d;
    d              = $urandom;
    data[b*32+:32] = d;
    par[b*2+:2]    = gpar(d) ^ {1'b0, flip};
    ue[b]          = u;
  endtask

  task automatic drive_beats(input int b, input int n, input int flip_at, input int ue_at);
    for (int i = 0; i < n; i++) begin
      set_beat(b, i == flip_at, i == ue_at);
      step();
    end
  endtask

  task automatic push(input int b, input logic [31:0] h, input logic pe, input logic u,
                      input logic pro);
    exp_t e;
    e.bank = 3'(b);
    e.opes = h[23:20];
    e.cba  = h[19:16];
    e.tag  = h[15:0];
    e.pe   = pe;
    e.ue   = u;
    e.pro  = pro;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && !evt_vld) break;
      @(posedge iol2clk);
      #1;
    end
  endtask

  task automatic test_reset();
    evt_rdy = 1'b0;
    do_reset();
    @(negedge iol2clk);
    checks++;
    if (evt_vld !== 1'b0) begin errors++; $display("FAIL rst_vld got %0b exp 0", evt_vld); end
    checks++;
    if ({evt_bank, evt_opes, evt_cba, evt_tag, evt_par_err, evt_ue, evt_proto_err} !== '0) begin
      errors++;
      $display("FAIL rst_fields got %h exp 0", {evt_bank, evt_opes, evt_cba, evt_tag});
    end
    checks++;
    if (bank_busy !== 8'h00) begin errors++; $display("FAIL rst_busy got %h exp 00", bank_busy); end
    checks++;
    if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL rst_ovf got %0b exp 0", ovf_sticky); end
    checks++;
    if (ue_cnt !== 16'd0) begin errors++; $display("FAIL rst_uecnt got %0d exp 0", ue_cnt); end
  endtask

  task automatic test_read_basic();
    evt_rdy = 1'b1;
    push(0, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
    set_hdr(0, 32'h0000_1234);
    step();
    checks++;
    if (bank_busy[0] !== 1'b1) begin errors++; $display("FAIL rd_busy got %0b exp 1", bank_busy[0]); end
    drive_beats(0, 15, -1, -1);
    checks++;
    if (evt_vld !== 1'b0) begin errors++; $display("FAIL rd_early got %0b exp 0", evt_vld); end
    drive_beats(0, 1, -1, -1);
    checks++;
    if (evt_vld !== 1'b0 || bank_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL rd_lat1 got vld=%0b busy=%0b exp 0 0", evt_vld, bank_busy[0]);
    end
    step();
    checks++;
    if (evt_vld !== 1'b1) begin errors++; $display("FAIL rd_lat2 got %0b exp 1", evt_vld); end
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rd_drain got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_ack_only();
    push(5, 32'h0040_00AB, 1'b0, 1'b0, 1'b0);
    set_hdr(5, 32'h0040_00AB);
    step();
    checks++;
    if (bank_busy[5] !== 1'b0 || evt_vld !== 1'b0) begin
      errors++;
      $display("FAIL ack_lat1 got busy=%0b vld=%0b exp 0 0", bank_busy[5], evt_vld);
    end
    step();
    checks++;
    if (evt_vld !== 1'b1 || evt_bank !== 3'd5) begin
      errors++;
      $display("FAIL ack_lat2 got vld=%0b bank=%0d exp 1 5", evt_vld, evt_bank);
    end
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL ack_drain got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_err_flags();
    push(2, 32'h0003_2222, 1'b1, 1'b1, 1'b0);
    set_hdr(2, 32'h0003_2222);
    step();
    drive_beats(2, 16, 7, 9);
    checks++;
    if (ue_cnt !== 16'd1) begin errors++; $display("FAIL err_uecnt got %0d exp 1", ue_cnt); end
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL err_drain got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_restart();
    push(3, 32'h0000_0111, 1'b0, 1'b0, 1'b1);
    push(3, 32'h0000_0222, 1'b0, 1'b0, 1'b0);
    set_hdr(3, 32'h0000_0111);
    step();
    drive_beats(3, 5, -1, -1);
    set_hdr(3, 32'h0000_0222);
    step();
    checks++;
    if (bank_busy[3] !== 1'b1) begin errors++; $display("FAIL rs_busy got %0b exp 1", bank_busy[3]); end
    drive_beats(3, 16, -1, -1);
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rs_drain got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_multi_bank();
    do_reset();
    evt_rdy = 1'b1;
    push(0, 32'h0040_00A0, 1'b0, 1'b0, 1'b0);
    push(1, 32'h0050_00A1, 1'b0, 1'b0, 1'b0);
    push(7, 32'h00C7_00A7, 1'b0, 1'b0, 1'b0);
    set_hdr(0, 32'h0040_00A0);
    set_hdr(1, 32'h0050_00A1);
    set_hdr(7, 32'h00C7_00A7);
    step();
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL mb_drain got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_overflow();
    evt_rdy = 1'b0;
    push(1, 32'h0040_00B1, 1'b0, 1'b0, 1'b0);
    set_hdr(1, 32'h0040_00B1);
    step();
    step();
    checks++;
    if (evt_vld !== 1'b1 || evt_bank !== 3'd1) begin
      errors++;
      $display("FAIL ov_hold got vld=%0b bank=%0d exp 1 1", evt_vld, evt_bank);
    end
    push(0, 32'h0040_00B0, 1'b0, 1'b0, 1'b0);
    set_hdr(0, 32'h0040_00B0);
    step();
    checks++;
    if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL ov_first got %0b exp 0", ovf_sticky); end
    set_hdr(0, 32'h0040_00BF);
    step();
    checks++;
    if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ov_set got %0b exp 1", ovf_sticky); end
    repeat (3) step();
    evt_rdy = 1'b1;
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL ov_drain got %0d exp 0", exp_q.size()); end
    checks++;
    if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ov_sticky got %0b exp 1", ovf_sticky); end
  endtask

  task automatic test_ue_count();
    ue = 8'b0000_0111;
    step();
    checks++;
    if (ue_cnt !== 16'd3) begin errors++; $display("FAIL ue_sum3 got %0d exp 3", ue_cnt); end
    ue = 8'hFF;
    step();
    checks++;
    if (ue_cnt !== 16'd11) begin errors++; $display("FAIL ue_sum8 got %0d exp 11", ue_cnt); end
    step();
    checks++;
    if (evt_vld !== 1'b0) begin errors++; $display("FAIL ue_noevt got %0b exp 0", evt_vld); end
  endtask

  task automatic test_reset_mid();
    evt_rdy = 1'b1;
    set_hdr(4, 32'h0000_0444);
    step();
    drive_beats(4, 8, -1, -1);
    set_beat(4, 1'b0, 1'b0);
    #2;
    rst_l = 1'b0;
    #1;
    checks++;
    if (evt_vld !== 1'b0 || bank_busy !== 8'h00 || ovf_sticky !== 1'b0 || ue_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rm_zero got vld=%0b busy=%h ovf=%0b ue=%0d exp 0 00 0 0",
               evt_vld, bank_busy, ovf_sticky, ue_cnt);
    end
    @(posedge iol2clk);
    #1;
    clr_in();
    rst_l = 1'b1;
    repeat (3) step();
    checks++;
    if (evt_vld !== 1'b0 || bank_busy[4] !== 1'b0) begin
      errors++;
      $display("FAIL rm_quiet got vld=%0b busy=%0b exp 0 0", evt_vld, bank_busy[4]);
    end
    push(4, 32'h0001_0455, 1'b0, 1'b0, 1'b0);
    set_hdr(4, 32'h0001_0455);
    step();
    drive_beats(4, 16, -1, -1);
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rm_drain got %0d exp 0", exp_q.size()); end
  endtask

  initial begin
    rst_l   = 1'b0;
    evt_rdy = 1'b0;
    clr_in();
    test_reset();
    test_read_basic();
    test_ack_only();
    test_err_flags();
    test_restart();
    test_multi_bank();
    test_overflow();
    test_ue_count();
    test_reset_mid();
    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
